regfile_wr_decoder: RTL and testbench



---
 rtl/regfile_wr_decoder.sv | 97 +++++++++
 tb/tb_regfile_wr_decoder.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/regfile_wr_decoder.sv
// Registered two-port write-enable decoder for the register file.
// Optional macro REGFILE_ZERO_REG_MASK_EN: address 0 acts as a hardwired-zero register.
module regfile_wr_decoder #(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wa_valid,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic              wb_valid,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic              clr_cnt,
  output logic [DEPTH-1:0]  we,
  output logic [DEPTH-1:0]  sel_b,
  output logic              conflict,
  output logic [1:0]        err_range,
  output logic [CNT_W-1:0]  conflict_cnt
);

  localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W+1)'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              a_in, b_in;
  logic              a_ok, b_ok;
  logic              a_zero, b_zero;
  logic [DEPTH-1:0]  we_d, we_q;
  logic [DEPTH-1:0]  sel_b_d, sel_b_q;
  logic              conflict_d, conflict_q;
  logic [1:0]        err_range_d, err_range_q;
  logic [CNT_W-1:0]  cnt_d, cnt_q;

  // Qualify each port: in range, and not the masked zero register.
  always_comb begin
    a_in = {1'b0, wa_addr} < DEPTH_L;
    b_in = {1'b0, wb_addr} < DEPTH_L;
`ifdef REGFILE_ZERO_REG_MASK_EN
    a_zero = wa_addr == '0;
    b_zero = wb_addr == '0;
`else
    a_zero = 1'b0;
    b_zero = 1'b0;
`endif
    a_ok = wa_valid && a_in && !a_zero;
    b_ok = wb_valid && b_in && !b_zero;
    err_range_d = {wb_valid && !b_in, wa_valid && !a_in};
    conflict_d  = a_ok && b_ok && (wa_addr == wb_addr);
  end

  // One-hot/two-hot decode; port B owns the data mux on a collision.
  always_comb begin
    we_d    = '0;
    sel_b_d = '0;
    for (int i = 0; i < DEPTH; i++) begin
      sel_b_d[i] = b_ok && (wb_addr == ADDR_W'(i));
      we_d[i]    = sel_b_d[i] || (a_ok && (wa_addr == ADDR_W'(i)));
    end
`ifdef REGFILE_ZERO_REG_MASK_EN
    we_d[0]    = 1'b0;
    sel_b_d[0] = 1'b0;
`endif
  end

  // Saturating collision counter; clear beats increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_cnt)
      cnt_d = '0;
    else if (conflict_d && cnt_q != CNT_MAX)
      cnt_d = cnt_q + 1'b1;
  end

  // Output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q        <= '0;
      sel_b_q     <= '0;
      conflict_q  <= 1'b0;
      err_range_q <= 2'b00;
      cnt_q       <= '0;
    end else begin
      we_q        <= we_d;
      sel_b_q     <= sel_b_d;
      conflict_q  <= conflict_d;
      err_range_q <= err_range_d;
      cnt_q       <= cnt_d;
    end
  end

  assign we           = we_q;
  assign sel_b        = sel_b_q;
  assign conflict     = conflict_q;
  assign err_range    = err_range_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wr_decoder.sv
// Directed vector bench for regfile_wr_decoder.
// Three instances: default, DEPTH=24, CNT_W=2.
module tb_regfile_wr_decoder;

  logic       clk = 1'b0;
  logic       rst_n, wa_valid, wb_valid, clr_cnt;
  logic [4:0] wa_addr, wb_addr;

  logic [31:0] m_we, m_sel;
  logic        m_conf;
  logic [1:0]  m_err;
  logic [7:0]  m_cnt;

  logic [23:0] d_we, d_sel;
  logic        d_conf;
  logic [1:0]  d_err;
  logic [7:0]  d_cnt;

  logic [31:0] c_we, c_sel;
  logic        c_conf;
  logic [1:0]  c_err;
  logic [1:0]  c_cnt;

  int nvec = 0;
  int nbad = 0;

  always #5 clk = ~clk;

  regfile_wr_decoder #(.ADDR_W(5), .DEPTH(32), .CNT_W(8)) u_main (
    .clk(clk), .rst_n(rst_n),
    .wa_valid(wa_valid), .wa_addr(wa_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .clr_cnt(clr_cnt),
    .we(m_we), .sel_b(m_sel), .conflict(m_conf),
    .err_range(m_err), .conflict_cnt(m_cnt)
  );

  regfile_wr_decoder #(.ADDR_W(5), .DEPTH(24), .CNT_W(8)) u_d24 (
    .clk(clk), .rst_n(rst_n),
    .wa_valid(wa_valid), .wa_addr(wa_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .clr_cnt(clr_cnt),
    .we(d_we), .sel_b(d_sel), .conflict(d_conf),
    .err_range(d_err), .conflict_cnt(d_cnt)
  );

  regfile_wr_decoder #(.ADDR_W(5), .DEPTH(32), .CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n),
    .wa_valid(wa_valid), .wa_addr(wa_addr),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .clr_cnt(clr_cnt),
    .we(c_we), .sel_b(c_sel), .conflict(c_conf),
    .err_range(c_err), .conflict_cnt(c_cnt)
  );

  typedef struct {
    logic        rst_n;
    logic        wav;
    logic [4:0]  waa;
    logic        wbv;
    logic [4:0]  wba;
    logic        clr;
    logic [31:0] we;
    logic [31:0] sel;
    logic        conf;
    logic [1:0]  err;
    logic [7:0]  cnt;
  } vec_t;

  vec_t tv[$];

  function automatic vec_t mk(
    logic r, logic av, logic [4:0] aa, logic bv, logic [4:0] ba,
    logic cl, logic [31:0] ew, logic [31:0] es, logic ec,
    logic [1:0] ee, logic [7:0] en);
    vec_t v;
    v.rst_n = r; v.wav = av; v.waa = aa; v.wbv = bv; v.wba = ba;
    v.clr = cl; v.we = ew; v.sel = es; v.conf = ec; v.err = ee;
    v.cnt = en;
    return v;
  endfunction

  task automatic chk(string nm, int idx, logic [31:0] act,
                     logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s step %0d: got %h expected %h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(logic r, logic av, logic [4:0] aa,
                       logic bv, logic [4:0] ba, logic cl);
    rst_n = r; wa_valid = av; wa_addr = aa;
    wb_valid = bv; wb_addr = ba; clr_cnt = cl;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; wa_valid = 1'b0; wb_valid = 1'b0;
    wa_addr = '0; wb_addr = '0; clr_cnt = 1'b0;
    #2;

    tv.push_back(mk(0,0,0,0,0,0, 32'h0,32'h0,0,2'b00,0));
    tv.push_back(mk(1,1,7,0,0,0, 32'h80,32'h0,0,2'b00,0));
    tv.push_back(mk(0,1,7,0,0,0, 32'h0,32'h0,0,2'b00,0));
    tv.push_back(mk(1,1,7,0,0,0, 32'h80,32'h0,0,2'b00,0));
    tv.push_back(mk(1,1,3,1,9,0, 32'h208,32'h200,0,2'b00,0));
    tv.push_back(mk(1,0,3,0,9,0, 32'h0,32'h0,0,2'b00,0));
    tv.push_back(mk(1,1,12,1,12,0, 32'h1000,32'h1000,1,2'b00,1));
    tv.push_back(mk(1,1,12,1,12,0, 32'h1000,32'h1000,1,2'b00,2));
    tv.push_back(mk(1,1,12,1,12,0, 32'h1000,32'h1000,1,2'b00,3));
    tv.push_back(mk(1,1,12,1,12,1, 32'h1000,32'h1000,1,2'b00,0));
    tv.push_back(mk(1,1,12,1,12,0, 32'h1000,32'h1000,1,2'b00,1));
    tv.push_back(mk(1,0,5,1,5,0, 32'h20,32'h20,0,2'b00,1));
    tv.push_back(mk(1,0,0,1,31,0, 32'h8000_0000,32'h8000_0000,0,2'b00,1));
    tv.push_back(mk(1,1,30,1,5,0, 32'h4000_0020,32'h20,0,2'b00,1));
`ifdef REGFILE_ZERO_REG_MASK_EN
    tv.push_back(mk(1,1,0,1,0,0, 32'h0,32'h0,0,2'b00,1));
    tv.push_back(mk(1,0,0,0,0,1, 32'h0,32'h0,0,2'b00,0));
    tv.push_back(mk(1,1,0,1,4,0, 32'h10,32'h10,0,2'b00,0));
`else
    tv.push_back(mk(1,1,0,1,0,0, 32'h1,32'h1,1,2'b00,2));
    tv.push_back(mk(1,0,0,0,0,1, 32'h0,32'h0,0,2'b00,0));
    tv.push_back(mk(1,1,0,1,4,0, 32'h11,32'h10,0,2'b00,0));
`endif

    for (int i = 0; i < tv.size(); i++) begin
      drive(tv[i].rst_n, tv[i].wav, tv[i].waa,
            tv[i].wbv, tv[i].wba, tv[i].clr);
      chk("main_we",   i, m_we,  tv[i].we);
      chk("main_selb", i, m_sel, tv[i].sel);
      chk("main_conf", i, 32'(m_conf), 32'(tv[i].conf));
      chk("main_err",  i, 32'(m_err),  32'(tv[i].err));
      chk("main_cnt",  i, 32'(m_cnt),  32'(tv[i].cnt));
    end

    // DEPTH=24 range checks
    drive(0,0,0,0,0,0);
    chk("d24_rst_cnt", 0, 32'(d_cnt), 32'h0);
    drive(1,1,30,1,5,0);
    chk("d24_we",   1, 32'(d_we),  32'h20);
    chk("d24_selb", 1, 32'(d_sel), 32'h20);
    chk("d24_err",  1, 32'(d_err), 32'h1);
    chk("d24_conf", 1, 32'(d_conf), 32'h0);
    drive(1,1,25,1,31,0);
    chk("d24_we",   2, 32'(d_we),  32'h0);
    chk("d24_err",  2, 32'(d_err), 32'h3);
    chk("d24_conf", 2, 32'(d_conf), 32'h0);
    drive(1,1,24,1,24,0);
    chk("d24_conf", 3, 32'(d_conf), 32'h0);
    chk("d24_err",  3, 32'(d_err), 32'h3);
    chk("d24_cnt",  3, 32'(d_cnt), 32'h0);
    drive(1,1,23,1,24,0);
    chk("d24_we",   4, 32'(d_we),  32'h80_0000);
    chk("d24_selb", 4, 32'(d_sel), 32'h0);
    chk("d24_err",  4, 32'(d_err), 32'h2);
    drive(1,0,30,0,31,0);
    chk("d24_err",  5, 32'(d_err), 32'h0);
    chk("main_err", 5, 32'(m_err), 32'h0);

    // CNT_W=2 saturation
    drive(0,0,0,0,0,0);
    chk("c2_rst_cnt", 0, 32'(c_cnt), 32'h0);
    for (int k = 1; k <= 5; k++) begin
      drive(1,1,12,1,12,0);
      chk("c2_cnt",  k, 32'(c_cnt), (k < 3) ? 32'(k) : 32'h3);
      chk("c2_conf", k, 32'(c_conf), 32'h1);
      chk("c2_we",   k, c_we,  32'h1000);
      chk("c2_selb", k, c_sel, 32'h1000);
      chk("c2_err",  k, 32'(c_err), 32'h0);
    end
    drive(1,1,12,1,12,1);
    chk("c2_clr", 6, 32'(c_cnt), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
